// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, ALU opcodes and the
// command values that the sequencer treats specially.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC  = 3'd1,
    S_M_ADD = 3'd2,
    S_M_SHL = 3'd3,
    S_M_SHR = 3'd4
  } state_e;

  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] OP_AND = 4'b0000;
  localparam logic [ALU_OPW-1:0] OP_OR  = 4'b0001;
  localparam logic [ALU_OPW-1:0] OP_XOR = 4'b0010;
  localparam logic [ALU_OPW-1:0] OP_NOT = 4'b0011;
  localparam logic [ALU_OPW-1:0] OP_SUB = 4'b0100;
  localparam logic [ALU_OPW-1:0] OP_ADD = 4'b0101;
  localparam logic [ALU_OPW-1:0] OP_RR  = 4'b0110;
  localparam logic [ALU_OPW-1:0] OP_RL  = 4'b0111;
  localparam logic [ALU_OPW-1:0] OP_INC = 4'b1000;
  localparam logic [ALU_OPW-1:0] OP_DEC = 4'b1001;
  localparam logic [ALU_OPW-1:0] OP_IN0 = 4'b1010;
  localparam logic [ALU_OPW-1:0] OP_IN1 = 4'b1011;
  localparam logic [ALU_OPW-1:0] OP_NEG = 4'b1100;

  localparam logic [ALU_OPW-1:0] CMD_MUL = 4'b1101;

  function automatic logic cmd_illegal(input logic [ALU_OPW-1:0] cmd);
    return cmd == 4'b1110 || cmd == 4'b1111;
  endfunction

  // Pass-through ops leave the zero flag alone.
  function automatic logic cmd_keeps_zf(input logic [ALU_OPW-1:0] cmd);
    return cmd == OP_IN0 || cmd == OP_IN1;
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU: the only arithmetic resource of the sequencer.
// RR/RL are one-bit logical shifts so the multiply loop drops bits cleanly.
module ALU
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [ALU_OPW-1:0]    OP,
  input  logic [DATA_WIDTH-1:0] IN0,
  input  logic [DATA_WIDTH-1:0] IN1,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic                  ZF
);

  always_comb begin
    OUT = '0;
    case (OP)
      OP_AND:  OUT = IN0 & IN1;
      OP_OR:   OUT = IN0 | IN1;
      OP_XOR:  OUT = IN0 ^ IN1;
      OP_NOT:  OUT = ~IN0;
      OP_SUB:  OUT = IN0 - IN1;
      OP_ADD:  OUT = IN0 + IN1;
      OP_RR:   OUT = IN0 >> 1;
      OP_RL:   OUT = IN0 << 1;
      OP_INC:  OUT = IN0 + 1'b1;
      OP_DEC:  OUT = IN0 - 1'b1;
      OP_IN0:  OUT = IN0;
      OP_IN1:  OUT = IN1;
      OP_NEG:  OUT = '0 - IN0;
      default: OUT = '0;
    endcase
  end

  assign ZF = (OUT == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer around a single ALU: one-cycle ALU commands and a
// fixed-latency shift-and-add multiply built from ADD/RL/RR steps.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [OP_WIDTH-1:0]   CMD,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] RES,
  output logic                  ZF_OUT,
  output logic                  ERR
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_e state_q, state_d;

  logic [ALU_OPW-1:0]    op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;     // operand 0, doubles as multiplicand
  logic [DATA_WIDTH-1:0] b_q, b_d;     // operand 1, doubles as multiplier
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zf_q, zf_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [ALU_OPW-1:0]    alu_op;
  logic [DATA_WIDTH-1:0] alu_in0, alu_in1, alu_out;
  logic                  alu_zf;
  logic                  last_iter;

  assign last_iter = (cnt_q == CW'(1));

  ALU #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .OP  (alu_op),
    .IN0 (alu_in0),
    .IN1 (alu_in1),
    .OUT (alu_out),
    .ZF  (alu_zf)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == CMD_MUL) ? S_M_ADD : S_IDLE;
      S_M_ADD: state_d = S_M_SHL;
      S_M_SHL: state_d = S_M_SHR;
      S_M_SHR: state_d = last_iter ? S_IDLE : S_M_ADD;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    BUSY = (state_q != S_IDLE);
  end

  // ALU operand steering
  always_comb begin
    alu_op  = OP_IN0;
    alu_in0 = acc_q;
    alu_in1 = a_q;
    case (state_q)
      S_EXEC: begin
        alu_op  = op_q;
        alu_in0 = a_q;
        alu_in1 = b_q;
      end
      S_M_ADD: alu_op = b_q[0] ? OP_ADD : OP_IN0;
      S_M_SHL: begin
        alu_op  = OP_RL;
        alu_in0 = a_q;
      end
      S_M_SHR: begin
        alu_op  = OP_RR;
        alu_in0 = b_q;
      end
      default: ;
    endcase
  end

  // Datapath register updates
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    zf_d   = zf_q;
    err_d  = err_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (START) begin
        op_d  = CMD[ALU_OPW-1:0];
        a_d   = A;
        b_d   = B;
        acc_d = '0;
        cnt_d = CW'(DATA_WIDTH);
        err_d = 1'b0;
      end
      S_EXEC: begin
        if (cmd_illegal(op_q)) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else if (op_q != CMD_MUL) begin
          res_d  = alu_out;
          if (!cmd_keeps_zf(op_q)) zf_d = alu_zf;
          done_d = 1'b1;
        end
      end
      S_M_ADD: acc_d = alu_out;
      S_M_SHL: a_d = alu_out;
      S_M_SHR: begin
        b_d   = alu_out;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          res_d  = acc_q;
          zf_d   = (acc_q == '0);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      zf_q   <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      zf_q   <= zf_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  assign DONE   = done_q;
  assign RES    = res_q;
  assign ZF_OUT = zf_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected completions are queued when a
// command is issued and checked on every DONE pulse.
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] CMD;
  logic [7:0] A, B;
  logic       BUSY, DONE, ZF_OUT, ERR;
  logic [7:0] RES;

  alu_sequencer #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CMD(CMD), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RES(RES), .ZF_OUT(ZF_OUT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] res;
    logic       zf;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_res = 8'h00;
  logic       m_zf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return ~a;
      4'd4:    return a - b;
      4'd5:    return a + b;
      4'd6:    return a >> 1;
      4'd7:    return a << 1;
      4'd8:    return a + 8'd1;
      4'd9:    return a - 8'd1;
      4'd10:   return a;
      4'd11:   return b;
      4'd12:   return 8'd0 - a;
      default: return 8'(a * b);
    endcase
  endfunction

  // Completion monitor
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(DONE), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res", 32'(RES), 32'(e.res));
        chk("zf",  32'(ZF_OUT), 32'(e.zf));
        chk("err", 32'(ERR), 32'(e.err));
      end
    end
  end

  // Called at a falling edge; leaves START low #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    START = 1'b1; CMD = op; A = a; B = b;
    if (op >= 4'd14) begin
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      m_res = ref_op(op, a, b);
      if (op != 4'd10 && op != 4'd11) m_zf = (m_res == 8'h00);
    end
    e.res = m_res;
    e.zf  = m_zf;
    sb_q.push_back(e);
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  // Counts busy cycles until DONE; returns at the falling edge where DONE is seen.
  task automatic wait_done(input string tag, input int exp_busy);
    int  n;
    logic seen;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (DONE) begin seen = 1'b1; break; end
      if (BUSY) n++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
  endtask

  task automatic settle(input string tag);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    issue(op, a, b);
    wait_done(tag, (op == 4'd13) ? 25 : 1);
    settle(tag);
  endtask

  initial begin
    int ndone;
    RST = 1'b1; START = 1'b0; CMD = 4'd0; A = 8'd0; B = 8'd0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_res",  32'(RES), 32'd0);
    chk("rst_zf",   32'(ZF_OUT), 32'd0);
    chk("rst_err",  32'(ERR), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    run("add", 4'd5, 8'h7F, 8'h01);
    run("sub", 4'd4, 8'h05, 8'h05);
    run("in1", 4'd11, 8'h00, 8'h33);
    chk("in1_zf_kept", 32'(ZF_OUT), 32'd1);
    run("mul_c_d", 4'd13, 8'h0C, 8'h0D);
    run("mul_10_10", 4'd13, 8'h10, 8'h10);

    // START while multiplying must be ignored
    issue(4'd13, 8'h07, 8'h09);
    repeat (5) @(negedge CLK);
    START = 1'b1; CMD = 4'd5; A = 8'h01; B = 8'h01;
    @(negedge CLK);
    START = 1'b0;
    wait_done("mul_busy_start", 19);
    settle("mul_busy_start");

    // Back-to-back: new command issued in the DONE cycle
    issue(4'd13, 8'h03, 8'h05);
    wait_done("b2b_mul", 25);
    issue(4'd5, 8'h01, 8'h02);
    wait_done("b2b_add", 1);
    settle("b2b_add");

    run("add80", 4'd5, 8'h7F, 8'h01);
    run("illegal", 4'd15, 8'h12, 8'h34);
    chk("illegal_err_held", 32'(ERR), 32'd1);
    chk("illegal_res_kept", 32'(RES), 32'h80);
    run("and_clr_err", 4'd0, 8'hF0, 8'h3C);
    run("illegal_e", 4'd14, 8'h00, 8'h00);

    for (int i = 0; i < 10; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run("rand", op, 8'($urandom), 8'($urandom));
    end

    // Reset in the middle of a multiply
    run("pre_rst", 4'd5, 8'h20, 8'h11);
    issue(4'd13, 8'h0C, 8'h0D);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    START = 1'b1; CMD = 4'd5; A = 8'h01; B = 8'h01;
    #1;
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    chk("arst_res",  32'(RES), 32'd0);
    chk("arst_zf",   32'(ZF_OUT), 32'd0);
    chk("arst_err",  32'(ERR), 32'd0);
    sb_q.delete();
    m_res = 8'h00; m_zf = 1'b0;
    repeat (2) @(negedge CLK);
    chk("arst_start_ignored", 32'(BUSY), 32'd0);
    START = 1'b0;
    RST = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE || BUSY) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    run("post_rst_add", 4'd5, 8'h7F, 8'h01);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width.
REQ-002 SHALL have parameter OP_WIDTH, default 4, command width.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  command request, sampled on CLK edge.
REQ-006 SHALL have port CMD  input  OP_WIDTH  command: 0000-1100 ALU ops, 1101 MUL, 1110/1111 illegal.
REQ-007 SHALL have port A  input  DATA_WIDTH  operand 0.
REQ-008 SHALL have port B  input  DATA_WIDTH  operand 1.
REQ-009 SHALL have port BUSY  output  1  high while a command is executing.
REQ-010 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-011 SHALL have port RES  output  DATA_WIDTH  registered result.
REQ-012 SHALL have port ZF_OUT  output  1  registered zero flag.
REQ-013 SHALL have port ERR  output  1  illegal-command flag, valid with DONE.

Function
REQ-014 SHALL use FSM states IDLE, EXEC, M_ADD, M_SHL, M_SHR; BUSY = (state != IDLE), combinational from state.
REQ-015 SHALL accept START only when state = IDLE (including the DONE cycle); latch A, B, CMD; clear ERR; START while BUSY ignored, no side effects.
REQ-016 SHALL on accepted CMD 0000-1100 go IDLE->EXEC; in EXEC drive ALU with OP=CMD, IN0=A_reg, IN1=B_reg; next edge capture RES, return to IDLE, DONE=1 next cycle (latency 2 edges from START edge to DONE visible... i.e. DONE high in the cycle after edge t0+1).
REQ-017 SHALL update ZF_OUT from ALU ZF for CMD 0000-1001 and 1100; CMD 1010/1011 SHALL leave ZF_OUT unchanged.
REQ-018 SHALL on CMD 1101 compute RES = (A*B) mod 2^DATA_WIDTH by shift-and-add through the single ALU instance: acc=0, mcand=A_reg, mplier=B_reg, counter=DATA_WIDTH.
REQ-019 SHALL per MUL iteration: M_ADD ALU OP=ADD(acc,mcand) written to acc if mplier[0]=1, else OP=IN0 (acc unchanged); M_SHL ALU OP=RL(mcand)->mcand; M_SHR ALU OP=RR(mplier)->mplier, counter decrement; exit to IDLE after counter reaches 0.
REQ-020 SHALL give MUL fixed latency: 3*DATA_WIDTH clocked cycles in MUL states (24 at DW=8), independent of operand values; then RES=acc, ZF_OUT=(acc==0), DONE pulse.
REQ-021 SHALL on CMD 1110/1111 not drive the ALU result into RES; return to IDLE after one edge, ERR=1 and DONE=1 in same cycle, RES and ZF_OUT unchanged.
REQ-022 SHALL hold RES, ZF_OUT, ERR stable between completions; DONE high exactly one cycle per accepted command.
REQ-023 SHALL apply all arithmetic modulo 2^DATA_WIDTH; no carry/overflow output.

Reset
REQ-024 SHALL on RST=1 immediately force state IDLE, BUSY=0, DONE=0, ERR=0, RES=0, ZF_OUT=0, internal registers 0.
REQ-025 SHALL abort any command in flight on reset; no DONE emitted for the aborted command after RST deasserts.
REQ-026 SHALL ignore START while RST=1.

Structure
REQ-027 SHALL place in a shared package/include: state encoding, CMD_MUL=4'b1101, ALU opcode constants (ADD 0101, RR 0110, RL 0111, IN0 1010).
REQ-028 SHALL instantiate exactly one ALU sub-module (module ALU, DATA_WIDTH passed through) as the only arithmetic resource; sequencer logic limited to muxing, counter and registers.

Verification
REQ-029 SHALL test ADD A=0x7F B=0x01 -> RES=0x80, ZF_OUT=0, DONE one cycle, BUSY high exactly one cycle.
REQ-030 SHALL test SUB A=0x05 B=0x05 -> RES=0x00 ZF_OUT=1; then CMD 1011 B=0x33 -> RES=0x33, ZF_OUT stays 1.
REQ-031 SHALL test MUL 0x0C*0x0D -> RES=0x9C, ZF_OUT=0, DONE 24 cycles after EXEC start; MUL 0x10*0x10 -> RES=0x00, ZF_OUT=1.
REQ-032 SHALL test START pulsed during MUL -> ignored, result unchanged; START in DONE cycle -> accepted back-to-back.
REQ-033 SHALL test CMD 1111 after RES=0x80 -> ERR=1 with DONE, RES=0x80 unchanged; next valid command clears ERR.
REQ-034 SHALL test RST asserted at MUL cycle 10 -> all outputs 0 immediately, no DONE after release, next ADD completes normally.
